// File: rtl/bsearch_datapath.sv
// Binary-search datapath: sorted array, search bounds, midpoint, fetched element and key.
// It also captures the final found/index result when the controller signals done.
module bsearch_datapath #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW:0]   len,
   input  logic [DW-1:0] key,
   input  logic          ld1,
   input  logic          ld2,
   input  logic          ld4,
   input  logic          ld5,
   input  logic          ld6,
   input  logic          ld7,
   input  logic          c1,
   input  logic          c2,
   input  logic          done,
   output logic [2:0]    eqz,
   output logic          signal,
   output logic          res_valid,
   output logic          res_found,
   output logic [AW-1:0] res_idx
);

   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] ONE_W = (AW+1)'(1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   low, high;
   logic [AW-1:0] mid, addr;
   logic [DW-1:0] r5, r7;
   logic          exhausted, done_q;
   logic [AW+1:0] mid_sum;
   logic [AW-1:0] mid_next;
   logic          capture, found_now;

   // Sum of two (AW+1)-bit bounds needs AW+2 bits; the halved value always fits in AW bits.
   assign mid_sum   = {1'b0, low} + {1'b0, high};
   assign mid_next  = mid_sum[AW:1];
   assign signal    = exhausted | (low > high);
   assign capture   = done & ~done_q;
   assign found_now = (eqz == 3'b010) & ~signal;

   always_comb begin
      // NOTE: default first so every path assigns eqz and no latch is inferred.
      eqz = 3'b001;
      if (r5 < r7)       eqz = 3'b100;
      else if (r5 == r7) eqz = 3'b010;
   end

   // NOTE: the array is deliberately left out of reset; it is plain storage that software reloads.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         low       <= '0;
         high      <= '0;
         mid       <= '0;
         addr      <= '0;
         r5        <= '0;
         r7        <= '0;
         exhausted <= 1'b0;
         done_q    <= 1'b0;
         res_valid <= 1'b0;
         res_found <= 1'b0;
         res_idx   <= '0;
      end else begin
         if (ld1) low <= c1 ? ({1'b0, mid} + ONE_W) : '0;

         if (ld2) begin
            if (!c2) begin
               if (len == '0) begin
                  high      <= '0;
                  exhausted <= 1'b1;
               end else begin
                  high      <= len - ONE_W;
                  exhausted <= 1'b0;
               end
            end else if (mid == '0) begin
               // Stepping below index 0 would wrap; flag exhaustion and keep high.
               exhausted <= 1'b1;
            end else begin
               high <= {1'b0, mid} - ONE_W;
            end
         end

         if (ld4) mid  <= mid_next;
         if (ld6) addr <= mid_next;
         if (ld5) r5   <= mem[addr];
         if (ld7) r7   <= key;

         done_q    <= done;
         res_valid <= capture;
         if (capture) begin
            res_found <= found_now;
            res_idx   <= found_now ? mid : '0;
         end
      end
   end

endmodule

// File: tb/tb_bsearch_datapath.sv
// Directed bench for bsearch_datapath: plays the controller role through
// hand-computed searches over mem[i] = 3i+1.
module tb_bsearch_datapath;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0]   len;
   logic [DW-1:0] key;
   logic          ld1, ld2, ld4, ld5, ld6, ld7, c1, c2, done;
   logic [2:0]    eqz;
   logic          signal, res_valid, res_found;
   logic [AW-1:0] res_idx;

   int n_checks = 0;
   int n_errors = 0;

   bsearch_datapath #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len(len), .key(key), .ld1(ld1), .ld2(ld2), .ld4(ld4), .ld5(ld5), .ld6(ld6),
      .ld7(ld7), .c1(c1), .c2(c2), .done(done), .eqz(eqz), .signal(signal),
      .res_valid(res_valid), .res_found(res_found), .res_idx(res_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      {ld1, ld2, ld4, ld5, ld6, ld7, c1, c2} = '0;
   endtask

   task automatic do_init();
      ld1 = 1'b1; ld2 = 1'b1;
      tick();
      clear_ctl();
   endtask

   // One 3-cycle iteration: mid/addr/key, fetch, then bound update chosen from the expected compare.
   task automatic iterate(input string tag, input logic [AW-1:0] exp_mid, input logic [2:0] exp_eqz);
      ld4 = 1'b1; ld6 = 1'b1; ld7 = 1'b1;
      tick();
      clear_ctl();
      check({tag, "_mid"}, 32'(dut.mid), 32'(exp_mid));
      ld5 = 1'b1;
      tick();
      clear_ctl();
      check({tag, "_eqz"}, 32'(eqz), 32'(exp_eqz));
      if (exp_eqz == 3'b100) begin
         ld1 = 1'b1; c1 = 1'b1;
         tick();
         clear_ctl();
      end else if (exp_eqz == 3'b001) begin
         ld2 = 1'b1; c2 = 1'b1;
         tick();
         clear_ctl();
      end
   endtask

   task automatic do_done(input string tag, input logic exp_found, input logic [AW-1:0] exp_idx);
      done = 1'b1;
      tick();
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_found"}, 32'(res_found), 32'(exp_found));
      check({tag, "_idx"}, 32'(res_idx), 32'(exp_idx));
      done = 1'b0;
      tick();
      check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      len = '0; key = '0; done = 1'b0;
      clear_ctl();
      tick();
      tick();
      rst = 1'b1;
      check("rst_eqz", 32'(eqz), 32'b010);
      check("rst_signal", 32'(signal), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);

      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(3 * i + 1);
         tick();
      end
      wr_en = 1'b0;

      // key=22 sits at index 7, found on the first probe
      len = 5'd16; key = 8'd22;
      do_init();
      check("k22_high", 32'(dut.high), 32'd15);
      iterate("k22_i0", 4'd7, 3'b010);
      do_done("k22", 1'b1, 4'd7);

      // key=4: mids 7,3,1
      key = 8'd4;
      do_init();
      iterate("k4_i0", 4'd7, 3'b001);
      iterate("k4_i1", 4'd3, 3'b001);
      iterate("k4_i2", 4'd1, 3'b010);
      do_done("k4", 1'b1, 4'd1);

      // key=0: walks down to mid 0, then high cannot drop further
      key = 8'd0;
      do_init();
      iterate("k0_i0", 4'd7, 3'b001);
      iterate("k0_i1", 4'd3, 3'b001);
      iterate("k0_i2", 4'd1, 3'b001);
      check("k0_sig_before", 32'(signal), 32'd0);
      iterate("k0_i3", 4'd0, 3'b001);
      check("k0_signal", 32'(signal), 32'd1);
      check("k0_high_kept", 32'(dut.high), 32'd0);
      do_done("k0", 1'b0, 4'd0);

      // key=100: low climbs to 16 without wrapping
      key = 8'd100;
      do_init();
      iterate("k100_i0", 4'd7, 3'b100);
      iterate("k100_i1", 4'd11, 3'b100);
      iterate("k100_i2", 4'd13, 3'b100);
      iterate("k100_i3", 4'd14, 3'b100);
      check("k100_sig_before", 32'(signal), 32'd0);
      iterate("k100_i4", 4'd15, 3'b100);
      check("k100_low", 32'(dut.low), 32'd16);
      check("k100_signal", 32'(signal), 32'd1);
      do_done("k100", 1'b0, 4'd0);

      // empty array is exhausted straight after init
      len = 5'd0; key = 8'd7;
      do_init();
      check("len0_signal", 32'(signal), 32'd1);
      do_done("len0", 1'b0, 4'd0);

      // len=5 clears exhaustion; key=13 at index 4
      len = 5'd5; key = 8'd13;
      do_init();
      check("len5_signal", 32'(signal), 32'd0);
      iterate("len5_i0", 4'd2, 3'b100);
      iterate("len5_i1", 4'd3, 3'b100);
      iterate("len5_i2", 4'd4, 3'b010);
      do_done("len5", 1'b1, 4'd4);

      // reset during the fetch cycle
      len = 5'd16; key = 8'd40;
      do_init();
      ld4 = 1'b1; ld6 = 1'b1; ld7 = 1'b1;
      tick();
      clear_ctl();
      ld5 = 1'b1; rst = 1'b0;
      tick();
      clear_ctl();
      rst = 1'b1;
      check("mrst_low", 32'(dut.low), 32'd0);
      check("mrst_high", 32'(dut.high), 32'd0);
      check("mrst_mid", 32'(dut.mid), 32'd0);
      check("mrst_r5", 32'(dut.r5), 32'd0);
      check("mrst_r7", 32'(dut.r7), 32'd0);
      check("mrst_eqz", 32'(eqz), 32'b010);
      check("mrst_signal", 32'(signal), 32'd0);
      check("mrst_valid", 32'(res_valid), 32'd0);
      check("mrst_found", 32'(res_found), 32'd0);

      // done held for 3 cycles: one pulse; R5==R7==0 with signal low reads as found at mid 0
      done = 1'b1;
      tick();
      check("hold_valid0", 32'(res_valid), 32'd1);
      check("hold_found", 32'(res_found), 32'd1);
      check("hold_idx", 32'(res_idx), 32'd0);
      tick();
      check("hold_valid1", 32'(res_valid), 32'd0);
      tick();
      check("hold_valid2", 32'(res_valid), 32'd0);
      done = 1'b0;
      tick();
      check("hold_found_kept", 32'(res_found), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
